// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pulls bytes from an upstream byte FIFO and sends them as
// async frames: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PAR, STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            par_q, par_d;

   logic tick, last_stop, can_start;

   assign tick      = (baud_q == BAUD_MAX);
   assign last_stop = (STOP_BITS == 2) ? stop_q : 1'b1;
   assign can_start = tx_en & ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shreg_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      baud_d     = tick ? '0 : baud_q + 1'b1;
      bit_d      = bit_q;
      stop_d     = stop_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      fifo_rd_en = 1'b0;
      tx         = 1'b1;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            busy   = 1'b0;
            baud_d = '0;
            if (can_start) state_d = REQ;
         end
         REQ: begin
            fifo_rd_en = 1'b1;
            baud_d     = '0;
            state_d    = LOAD;
         end
         // FIFO output is registered, so the byte is only valid here
         LOAD: begin
            baud_d  = '0;
            shreg_d = fifo_data;
            par_d   = (^fifo_data) ^ (PARITY_ODD != 0);
            stop_d  = 1'b0;
            state_d = START;
         end
         START: begin
            tx = 1'b0;
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            tx = shreg_q[bit_q];
            if (tick) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PAR : STOP;
            end
         end
         PAR: begin
            tx = par_q;
            if (tick) state_d = STOP;
         end
         STOP: begin
            frame_done = tick & last_stop;
            if (tick) begin
               if (last_stop) state_d = can_start ? REQ : IDLE;
               else           stop_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
